// File: rtl/cls_accel_text_feed_pkg.sv
// Shared types, ASCII constants and formatting helpers for the accelerometer text feeder.
package cls_accel_text_feed_pkg;

  typedef logic [127:0] t_pmod_cls_ascii_line_16;
  typedef logic signed [11:0] t_accel_sample;

  localparam logic [7:0] ASCII_CLS_CHAR_PLUS  = 8'h2B;
  localparam logic [7:0] ASCII_CLS_CHAR_MINUS = 8'h2D;
  localparam logic [7:0] ASCII_CLS_CHAR_COLON = 8'h3A;
  localparam logic [7:0] ASCII_CLS_CHAR_SPACE = 8'h20;
  localparam logic [7:0] ASCII_CLS_CHAR_X     = 8'h58;
  localparam logic [7:0] ASCII_CLS_CHAR_Y     = 8'h59;
  localparam logic [7:0] ASCII_CLS_CHAR_Z     = 8'h5A;
  localparam logic [7:0] ASCII_CLS_CHAR_T     = 8'h54;

  localparam t_pmod_cls_ascii_line_16 c_line_blank = {16{ASCII_CLS_CHAR_SPACE}};

  // -2048 maps to 12'h800, which reads as 2048 once treated as unsigned
  function automatic logic [11:0] accel_magnitude(t_accel_sample v);
    logic [11:0] u;
    u = v;
    return v[11] ? (~u + 12'd1) : u;
  endfunction

  // "L:sdddd " -- label, colon, sign, four BCD digits, trailing space
  function automatic logic [63:0] fmt_field(logic [7:0] label, logic neg, logic [15:0] bcd);
    return {label, ASCII_CLS_CHAR_COLON,
            (neg ? ASCII_CLS_CHAR_MINUS : ASCII_CLS_CHAR_PLUS),
            {4'h3, bcd[15:12]}, {4'h3, bcd[11:8]}, {4'h3, bcd[7:4]}, {4'h3, bcd[3:0]},
            ASCII_CLS_CHAR_SPACE};
  endfunction

endpackage

// File: rtl/cls_accel_text_feed_if.sv
// Command/data handshake between the text feeder (master) and the CLS SPI driver (slave).
interface cls_accel_text_feed_if;
  import cls_accel_text_feed_pkg::*;

  logic                    i_command_ready;
  logic                    o_cmd_wr_clear_display;
  logic                    o_cmd_wr_text_line1;
  logic                    o_cmd_wr_text_line2;
  t_pmod_cls_ascii_line_16 o_dat_ascii_line1;
  t_pmod_cls_ascii_line_16 o_dat_ascii_line2;
  logic                    o_busy;

  modport master (
    input  i_command_ready,
    output o_cmd_wr_clear_display, o_cmd_wr_text_line1, o_cmd_wr_text_line2,
    output o_dat_ascii_line1, o_dat_ascii_line2, o_busy
  );

  modport slave (
    output i_command_ready,
    input  o_cmd_wr_clear_display, o_cmd_wr_text_line1, o_cmd_wr_text_line2,
    input  o_dat_ascii_line1, o_dat_ascii_line2, o_busy
  );

endinterface

// File: rtl/cls_accel_text_feed_bcd.sv
// Sequential double-dabble: 12-bit magnitude to four BCD digits, one step per ce pulse.
module bin12_to_bcd4_seq (
  input  logic        i_ext_spi_clk_x,
  input  logic        i_rst_n,
  input  logic        i_ce,
  input  logic        i_start,
  input  logic [11:0] i_mag,
  output logic        o_done,
  output logic [15:0] o_bcd
);

  logic [27:0] sr;
  logic [27:0] sr_adj;
  logic [3:0]  cnt;
  logic        busy;

  function automatic logic [15:0] dd_adjust(logic [15:0] b);
    logic [15:0] r;
    r = b;
    for (int i = 0; i < 4; i++) begin
      if (b[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = b[i*4 +: 4] + 4'd3;
    end
    return r;
  endfunction

  assign sr_adj = {dd_adjust(sr[27:12]), sr[11:0]};

  // done is only refreshed on ce so a consumer that also runs on ce cannot miss it
  always_ff @(posedge i_ext_spi_clk_x or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sr     <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
      o_done <= 1'b0;
    end else if (i_ce) begin
      o_done <= 1'b0;
      if (busy) begin
        sr  <= {sr_adj[26:0], 1'b0};
        cnt <= cnt - 4'd1;
        if (cnt == 4'd1) begin
          busy   <= 1'b0;
          o_done <= 1'b1;
        end
      end else if (i_start) begin
        sr   <= {16'h0000, i_mag};
        cnt  <= 4'd12;
        busy <= 1'b1;
      end
    end
  end

  assign o_bcd = sr[27:12];

endmodule

// File: rtl/cls_accel_text_feed.sv
// Accelerometer/temperature to two 16-char ASCII lines, fed to the PMOD CLS driver
// through its command_ready level/ack handshake at a limited refresh rate.
//
// state        | meaning
// ST_BOOT_WAIT | wait for driver ready after reset
// ST_CLR_REQ   | clear-display command held high
// ST_CLR_ACK   | driver accepted clear, wait for ready
// ST_IDLE      | wait for refresh timer saturated and a pending sample
// ST_CONV      | convert x, y, z, temp snapshots to BCD
// ST_L1_REQ    | write-line-1 command held high
// ST_L1_ACK    | driver accepted line 1, wait for ready
// ST_L2_REQ    | write-line-2 command held high
// ST_L2_ACK    | driver accepted line 2, wait for ready
module cls_accel_text_feed
  import cls_accel_text_feed_pkg::*;
#(
  parameter int parm_fast_simulation = 0,
  parameter int FCLK_ce              = 2500000,
  parameter int parm_refresh_ms      = 200
) (
  input  logic                 i_ext_spi_clk_x,
  input  logic                 i_rst_n,
  input  logic                 i_spi_ce_4x,
  input  logic                 i_accel_valid,
  input  t_accel_sample        i_accel_x,
  input  t_accel_sample        i_accel_y,
  input  t_accel_sample        i_accel_z,
  input  t_accel_sample        i_accel_temp,
  cls_accel_text_feed_if.master feed
);

  localparam int c_t_refresh = FCLK_ce / 1000 * ((parm_fast_simulation != 0) ? 1 : parm_refresh_ms);
  localparam int c_timer_w   = (c_t_refresh > 1) ? $clog2(c_t_refresh) : 1;
  localparam logic [c_timer_w-1:0] c_timer_sat = c_timer_w'(c_t_refresh - 1);

  typedef enum logic [3:0] {
    ST_BOOT_WAIT,
    ST_CLR_REQ,
    ST_CLR_ACK,
    ST_IDLE,
    ST_CONV,
    ST_L1_REQ,
    ST_L1_ACK,
    ST_L2_REQ,
    ST_L2_ACK
  } t_feed_state;

  localparam t_feed_state fsm_safe_state = ST_BOOT_WAIT;

  t_feed_state             state;
  logic [c_timer_w-1:0]    timer;
  logic                    timer_sat;
  logic                    pending;
  logic                    conv_enter;
  t_accel_sample           hold [4];
  t_accel_sample           snap [4];
  logic [2:0]              n_issued;
  logic [2:0]              n_done;
  logic [15:0]             bcd_res [3];
  logic                    conv_start;
  logic                    conv_done;
  logic [11:0]             conv_mag;
  logic [15:0]             conv_bcd;
  logic                    cmd_clr;
  logic                    cmd_l1;
  logic                    cmd_l2;
  logic                    busy_r;
  t_pmod_cls_ascii_line_16 line1;
  t_pmod_cls_ascii_line_16 line2;

  assign timer_sat  = (timer == c_timer_sat);
  assign conv_enter = i_spi_ce_4x && (state == ST_IDLE) && timer_sat && pending;

  always_ff @(posedge i_ext_spi_clk_x or negedge i_rst_n) begin
    if (!i_rst_n) begin
      timer <= '0;
    end else if (conv_enter) begin
      timer <= '0;
    end else if (i_spi_ce_4x && !timer_sat) begin
      timer <= timer + 1'b1;
    end
  end

  // A sample arriving on the conversion-entry clock stays pending for the next refresh
  always_ff @(posedge i_ext_spi_clk_x or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pending <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        hold[i] <= '0;
        snap[i] <= '0;
      end
    end else begin
      if (i_accel_valid) begin
        pending <= 1'b1;
        hold[0] <= i_accel_x;
        hold[1] <= i_accel_y;
        hold[2] <= i_accel_z;
        hold[3] <= i_accel_temp;
      end else if (conv_enter) begin
        pending <= 1'b0;
      end
      if (conv_enter) begin
        for (int i = 0; i < 4; i++) snap[i] <= hold[i];
      end
    end
  end

  // Next value is started on the same ce that consumes the previous done
  assign conv_start = (state == ST_CONV) && (n_issued != 3'd4) &&
                      ((n_issued == n_done) || conv_done);
  assign conv_mag   = accel_magnitude(snap[n_issued[1:0]]);

  bin12_to_bcd4_seq u_bcd (
    .i_ext_spi_clk_x (i_ext_spi_clk_x),
    .i_rst_n         (i_rst_n),
    .i_ce            (i_spi_ce_4x),
    .i_start         (conv_start),
    .i_mag           (conv_mag),
    .o_done          (conv_done),
    .o_bcd           (conv_bcd)
  );

  always_ff @(posedge i_ext_spi_clk_x or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= ST_BOOT_WAIT;
      cmd_clr    <= 1'b0;
      cmd_l1     <= 1'b0;
      cmd_l2     <= 1'b0;
      busy_r     <= 1'b1;
      n_issued   <= '0;
      n_done     <= '0;
      bcd_res[0] <= '0;
      bcd_res[1] <= '0;
      bcd_res[2] <= '0;
      line1      <= c_line_blank;
      line2      <= c_line_blank;
    end else if (i_spi_ce_4x) begin
      case (state)
        ST_BOOT_WAIT: if (feed.i_command_ready) begin
          state   <= ST_CLR_REQ;
          cmd_clr <= 1'b1;
        end
        ST_CLR_REQ: if (!feed.i_command_ready) begin
          state   <= ST_CLR_ACK;
          cmd_clr <= 1'b0;
        end
        ST_CLR_ACK: if (feed.i_command_ready) begin
          state  <= ST_IDLE;
          busy_r <= 1'b0;
        end
        ST_IDLE: if (conv_enter) begin
          state    <= ST_CONV;
          busy_r   <= 1'b1;
          n_issued <= '0;
          n_done   <= '0;
        end
        ST_CONV: begin
          if (conv_start) n_issued <= n_issued + 3'd1;
          if (conv_done) begin
            if (n_done == 3'd3) begin
              line1  <= {fmt_field(ASCII_CLS_CHAR_X, snap[0][11], bcd_res[0]),
                         fmt_field(ASCII_CLS_CHAR_Y, snap[1][11], bcd_res[1])};
              line2  <= {fmt_field(ASCII_CLS_CHAR_Z, snap[2][11], bcd_res[2]),
                         fmt_field(ASCII_CLS_CHAR_T, snap[3][11], conv_bcd)};
              state  <= ST_L1_REQ;
              cmd_l1 <= 1'b1;
            end else begin
              bcd_res[n_done[1:0]] <= conv_bcd;
              n_done <= n_done + 3'd1;
            end
          end
        end
        ST_L1_REQ: if (!feed.i_command_ready) begin
          state  <= ST_L1_ACK;
          cmd_l1 <= 1'b0;
        end
        ST_L1_ACK: if (feed.i_command_ready) begin
          state  <= ST_L2_REQ;
          cmd_l2 <= 1'b1;
        end
        ST_L2_REQ: if (!feed.i_command_ready) begin
          state  <= ST_L2_ACK;
          cmd_l2 <= 1'b0;
        end
        ST_L2_ACK: if (feed.i_command_ready) begin
          state  <= ST_IDLE;
          busy_r <= 1'b0;
        end
        default: begin
          state   <= fsm_safe_state;
          cmd_clr <= 1'b0;
          cmd_l1  <= 1'b0;
          cmd_l2  <= 1'b0;
          busy_r  <= 1'b1;
        end
      endcase
    end
  end

  assign feed.o_cmd_wr_clear_display = cmd_clr;
  assign feed.o_cmd_wr_text_line1    = cmd_l1;
  assign feed.o_cmd_wr_text_line2    = cmd_l2;
  assign feed.o_dat_ascii_line1      = line1;
  assign feed.o_dat_ascii_line2      = line2;
  assign feed.o_busy                 = busy_r;

endmodule

// File: tb/tb_cls_accel_text_feed.sv
// Directed bench for cls_accel_text_feed with an emulated CLS driver and a line/command model.
module tb_cls_accel_text_feed;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ce = 1'b0;
  logic        valid = 1'b0;
  logic [11:0] ax = '0, ay = '0, az = '0, at = '0;
  logic        ready = 1'b0;
  logic        drv_en = 1'b0;
  logic        drv_hold = 1'b0;

  int checks = 0;
  int errors = 0;
  int n_ce = 0;
  int n_cmd [3] = '{0, 0, 0};
  int exp_next = 0;

  localparam logic [127:0] SP = {16{8'h20}};
  logic [127:0] cur_l1 = SP, cur_l2 = SP;
  logic [255:0] exp_q [$];
  logic [2:0]   prev_cmds = '0;

  cls_accel_text_feed_if bus ();
  assign bus.i_command_ready = ready;

  cls_accel_text_feed #(
    .parm_fast_simulation (1),
    .FCLK_ce              (100000),
    .parm_refresh_ms      (200)
  ) dut (
    .i_ext_spi_clk_x (clk),
    .i_rst_n         (rst_n),
    .i_spi_ce_4x     (ce),
    .i_accel_valid   (valid),
    .i_accel_x       (ax),
    .i_accel_y       (ay),
    .i_accel_z       (az),
    .i_accel_temp    (at),
    .feed            (bus.master)
  );

  always #5 clk = ~clk;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ce every third clock, changed on the falling edge
  initial begin
    int div = 0;
    forever begin
      @(negedge clk);
      div = (div == 2) ? 0 : div + 1;
      ce  = (div == 0);
      if (ce) n_ce++;
    end
  end

  function automatic logic [63:0] fld(byte lbl, int v);
    string s;
    logic [63:0] r;
    s = $sformatf("%c:%s%04d ", lbl, (v < 0) ? "-" : "+", (v < 0) ? -v : v);
    for (int i = 0; i < 8; i++) r[63-8*i -: 8] = s[i];
    return r;
  endfunction

  task automatic expect_pair(int x, int y, int z, int t);
    exp_q.push_back({fld("X", x), fld("Y", y), fld("Z", z), fld("T", t)});
  endtask

  task automatic chk(string name, logic [127:0] act, logic [127:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, want);
    end
  endtask

  task automatic send(int x, int y, int z, int t);
    @(negedge clk);
    valid = 1'b1;
    ax = x[11:0]; ay = y[11:0]; az = z[11:0]; at = t[11:0];
    @(negedge clk);
    valid = 1'b0;
  endtask

  task automatic wait_cmd(string name, int k, int target, int budget);
    int n = 0;
    while (n_cmd[k] < target && n < budget) begin @(negedge clk); n++; end
    checks++;
    if (n_cmd[k] < target) begin
      errors++;
      $display("FAIL %s timeout: count %0d want %0d", name, n_cmd[k], target);
    end
  endtask

  task automatic wait_busy(string name, logic val, int budget);
    int n = 0;
    while (bus.o_busy !== val && n < budget) begin @(negedge clk); n++; end
    checks++;
    if (bus.o_busy !== val) begin
      errors++;
      $display("FAIL %s timeout: busy %b want %b", name, bus.o_busy, val);
    end
  endtask

  // Emulated CLS driver: accepts a command after 3 clocks, returns ready 4 clocks after it drops
  initial begin
    int dstate = 0;
    int dcnt = 0;
    logic [2:0] c;
    forever begin
      @(negedge clk);
      c = {bus.o_cmd_wr_text_line2, bus.o_cmd_wr_text_line1, bus.o_cmd_wr_clear_display};
      if (!rst_n) begin
        dstate = 0; dcnt = 0; ready = drv_en;
      end else begin
        case (dstate)
          0: begin
            ready = drv_en;
            if (drv_en && !drv_hold && c != 3'b000) begin
              dcnt++;
              if (dcnt >= 3) begin ready = 1'b0; dstate = 1; dcnt = 0; end
            end else dcnt = 0;
          end
          1: if (c == 3'b000) dstate = 2;
          default: begin
            dcnt++;
            if (dcnt >= 4) begin ready = 1'b1; dstate = 0; dcnt = 0; end
          end
        endcase
      end
    end
  end

  // Model compare: command order, one-hot, handshake drop, and line contents every cycle
  always @(negedge clk) begin : mon
    logic [2:0] cmds;
    cmds = {bus.o_cmd_wr_text_line2, bus.o_cmd_wr_text_line1, bus.o_cmd_wr_clear_display};
    if (!rst_n) begin
      cur_l1 = SP; cur_l2 = SP; exp_next = 0; prev_cmds = '0;
    end else begin
      checks++;
      if ($countones(cmds) > 1 || (cmds != 3'b000 && !bus.o_busy)) begin
        errors++;
        $display("FAIL cmd_onehot: cmds %b busy %b, want at most one cmd and busy high", cmds, bus.o_busy);
      end
      for (int k = 0; k < 3; k++) begin
        if (cmds[k] && !prev_cmds[k]) begin
          checks++;
          if (k != exp_next) begin
            errors++;
            $display("FAIL cmd_order: got cmd %0d want cmd %0d", k, exp_next);
          end
          exp_next = (k == 1) ? 2 : 1;
          n_cmd[k]++;
          if (k == 1) begin
            checks++;
            if (exp_q.size() == 0) begin
              errors++;
              $display("FAIL unexpected_line_write: got line1 command, want none");
            end else {cur_l1, cur_l2} = exp_q.pop_front();
          end
        end
        if (!cmds[k] && prev_cmds[k]) begin
          checks++;
          if (ready !== 1'b0) begin
            errors++;
            $display("FAIL cmd_drop: cmd %0d dropped with ready %b, want 0", k, ready);
          end
        end
      end
      checks++;
      if (bus.o_dat_ascii_line1 !== cur_l1 || bus.o_dat_ascii_line2 !== cur_l2) begin
        errors++;
        $display("FAIL lines: got %h/%h want %h/%h", bus.o_dat_ascii_line1, bus.o_dat_ascii_line2, cur_l1, cur_l2);
      end
      prev_cmds = cmds;
    end
  end

  initial begin
    int t0, b1, b2;
    logic [127:0] lit1, lit2;
    logic [55:0]  lit7;

    // reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst_clear", bus.o_cmd_wr_clear_display, 1'b0);
    chk("rst_l1", bus.o_cmd_wr_text_line1, 1'b0);
    chk("rst_l2", bus.o_cmd_wr_text_line2, 1'b0);
    chk("rst_busy", bus.o_busy, 1'b1);
    chk("rst_line1", bus.o_dat_ascii_line1, SP);
    chk("rst_line2", bus.o_dat_ascii_line2, SP);
    @(negedge clk);
    rst_n = 1'b1;

    // boot: ready low for 100 ce, then exactly one clear
    t0 = n_ce;
    while (n_ce < t0 + 100) @(negedge clk);
    chk("boot_no_clear", n_cmd[0], 0);
    chk("boot_busy", bus.o_busy, 1'b1);
    drv_en = 1'b1;
    wait_cmd("boot_clear", 0, 1, 300);
    wait_busy("boot_idle", 1'b0, 300);
    chk("boot_clear_count", n_cmd[0], 1);
    chk("boot_no_line", n_cmd[1], 0);

    // nominal sample
    expect_pair(1234, -567, 89, 412);
    send(1234, -567, 89, 412);
    wait_cmd("pair_a", 2, 1, 3000);
    wait_busy("pair_a_idle", 1'b0, 300);
    lit1 = "X:+1234 Y:-0567 "; lit2 = "Z:+0089 T:+0412 ";
    chk("pair_a_line1", bus.o_dat_ascii_line1, lit1);
    chk("pair_a_line2", bus.o_dat_ascii_line2, lit2);

    // extremes
    expect_pair(-2048, 2047, 0, -1);
    send(-2048, 2047, 0, -1);
    wait_cmd("pair_b", 2, 2, 3000);
    wait_busy("pair_b_idle", 1'b0, 300);
    lit1 = "X:-2048 Y:+2047 "; lit2 = "Z:+0000 T:-0001 ";
    chk("pair_b_line1", bus.o_dat_ascii_line1, lit1);
    chk("pair_b_line2", bus.o_dat_ascii_line2, lit2);

    // no new samples for 4 refresh periods
    b1 = n_cmd[1]; b2 = n_cmd[2];
    repeat (1200) @(negedge clk);
    chk("idle_no_line1", n_cmd[1], b1);
    chk("idle_no_line2", n_cmd[2], b2);

    // sample mid-period, then three quick pulses, then a pulse during conversion
    expect_pair(100, 11, -22, 33);
    send(100, 11, -22, 33);
    wait_cmd("pair_c", 2, b2 + 1, 3000);
    wait_busy("pair_c_idle", 1'b0, 300);
    expect_pair(7, 11, -22, 33);
    expect_pair(-9, 11, -22, 33);
    send(3, 11, -22, 33);
    send(5, 11, -22, 33);
    send(7, 11, -22, 33);
    wait_busy("conv_start", 1'b1, 1500);
    repeat (10) @(negedge clk);
    send(-9, 11, -22, 33);
    wait_cmd("pair_7", 1, b1 + 2, 3000);
    lit7 = "X:+0007";
    chk("pair_7_line1", bus.o_dat_ascii_line1[127:72], lit7);
    wait_cmd("pair_m9", 2, b2 + 3, 3000);
    wait_busy("pair_m9_idle", 1'b0, 300);
    chk("pair_m9_count", n_cmd[1], b1 + 3);
    chk("queue_empty_1", exp_q.size(), 0);

    // reset while line1 request is held
    drv_hold = 1'b1;
    expect_pair(55, 66, 77, 88);
    send(55, 66, 77, 88);
    wait_cmd("l1_hold", 1, b1 + 4, 3000);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_l1", bus.o_cmd_wr_text_line1, 1'b0);
    chk("mid_rst_clear", bus.o_cmd_wr_clear_display, 1'b0);
    chk("mid_rst_busy", bus.o_busy, 1'b1);
    chk("mid_rst_line1", bus.o_dat_ascii_line1, SP);
    chk("mid_rst_line2", bus.o_dat_ascii_line2, SP);
    repeat (3) @(negedge clk);
    drv_hold = 1'b0;
    rst_n = 1'b1;
    wait_cmd("reboot_clear", 0, 2, 300);
    wait_busy("reboot_idle", 1'b0, 300);

    // first sample after reboot waits a full refresh period
    b2 = n_cmd[2];
    expect_pair(1, -10, 100, -1000);
    send(1, -10, 100, -1000);
    wait_cmd("pair_d", 2, b2 + 1, 3000);
    wait_busy("pair_d_idle", 1'b0, 300);
    lit1 = "X:+0001 Y:-0010 "; lit2 = "Z:+0100 T:-1000 ";
    chk("pair_d_line1", bus.o_dat_ascii_line1, lit1);
    chk("pair_d_line2", bus.o_dat_ascii_line2, lit2);
    chk("queue_empty_2", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cls_accel_text_feed.md
Name: cls_accel_text_feed

Overview:
- Upstream feeder for the PMOD CLS SPI driver. Captures accelerometer X/Y/Z and temperature samples and converts each to signed 4-digit decimal ASCII.
- Formats the results into two 16-character display lines. Issues clear-display once after boot, then rate-limited line1/line2 write commands through the driver's command_ready handshake.

Parameters:
- parm_fast_simulation, 0, nonzero shortens the refresh period to 1 ms for simulation.
- FCLK_ce, 2500000, frequency in Hz of i_spi_ce_4x pulses; FSM and timer advance only on these pulses.
- parm_refresh_ms, 200, display refresh period in ms when parm_fast_simulation=0.

Ports:
- i_ext_spi_clk_x  in  1  system clock (one clock domain).
- i_rst_n  in  1  asynchronous, active-low reset.
- i_spi_ce_4x  in  1  clock enable shared with the CLS driver.
- i_accel_valid  in  1  one-clock pulse; sample inputs are valid.
- i_accel_x, i_accel_y, i_accel_z, i_accel_temp  in  12 each  signed two's-complement samples.
- i_command_ready  in  1  from the CLS driver's o_command_ready.
- o_cmd_wr_clear_display  out  1  clear-display command level.
- o_cmd_wr_text_line1  out  1  write-line-1 command level.
- o_cmd_wr_text_line2  out  1  write-line-2 command level.
- o_dat_ascii_line1, o_dat_ascii_line2  out  128 (t_pmod_cls_ascii_line_16)  display text; character 0 in bits [127:120].
- o_busy  out  1  high in every state except ST_IDLE.

Behaviour:
- Reset (async, i_rst_n=0):
  - All command outputs 0; o_busy 1; FSM in ST_BOOT_WAIT; refresh timer 0; sample-pending flag 0.
  - Both lines = 16 × 8'h20 (spaces).
  - Reset mid-handshake abandons the command immediately; the driver owns recovery.
- Sample capture:
  - Every clock on which i_accel_valid=1, the four inputs load into holding registers and the pending flag sets.
  - Newest sample wins; capture is not gated by i_spi_ce_4x.
  - Pending clears on the ce cycle the FSM enters ST_CONV. If i_accel_valid arrives in that same clock, pending stays set.
- Refresh timer:
  - Counts i_spi_ce_4x pulses and saturates at c_t_refresh-1, where c_t_refresh = FCLK_ce/1000*(parm_fast_simulation ? 1 : parm_refresh_ms).
  - Clears on entry to ST_CONV.
- FSM (transitions only on i_spi_ce_4x):
  - ST_BOOT_WAIT: when i_command_ready=1 → ST_CLR_REQ.
  - ST_CLR_REQ: o_cmd_wr_clear_display=1; when i_command_ready=0 (driver accepted) → ST_CLR_ACK.
  - ST_CLR_ACK: when i_command_ready=1 → ST_IDLE.
  - ST_IDLE: when timer saturated AND pending=1 → ST_CONV; otherwise stay. The timer saturated with no new sample causes no write.
  - ST_CONV: converts the x, y, z, temp snapshots in sequence through the sub-module. After the 4th done, updates both line registers in one cycle → ST_L1_REQ.
  - ST_L1_REQ / ST_L1_ACK and ST_L2_REQ / ST_L2_ACK: same level/ack pattern as clear, using o_cmd_wr_text_line1, then o_cmd_wr_text_line2. ST_L2_ACK → ST_IDLE.
  - Command outputs are registered. At most one is high at any time, and only in its REQ state.
  - Line outputs change only on the ST_CONV exit cycle, so they are stable through both handshakes.
- Formatting:
  - Line1 = "X:" s d3 d2 d1 d0 " " "Y:" s d3 d2 d1 d0 " ".
  - Line2 = "Z:" … " " "T:" … " ".
  - s = '+' (8'h2B) for ≥0, '-' (8'h2D) for <0. Digits = 8'h30+BCD, leading zeros kept.
  - Magnitude = 12-bit unsigned |v|; -2048 → 2048, no overflow.
- Conversion latency: 12 shift cycles + 1 load cycle per value, on ce pulses; 52 ce pulses per ST_CONV.
- Inputs changing during ST_CONV affect only the holding registers, never the in-progress snapshot.

Decomposition:
- Add to pmod_stand_spi_solo_pkg: ASCII_CLS_CHAR_PLUS, ASCII_CLS_CHAR_MINUS, ASCII_CLS_CHAR_COLON, ASCII_CLS_CHAR_SPACE, and the t_accel_sample (signed 12-bit) typedef.
- Local to this block: the FSM enum (fsm_safe_state default to ST_BOOT_WAIT).
- Sub-module bin12_to_bcd4_seq:
  - Sequential double-dabble.
  - Ports: clock, i_rst_n, ce, start, 12-bit magnitude in; done pulse and 16-bit BCD out.
  - start while busy is ignored.

Test Plan:
- Boot: hold i_command_ready=0 for 100 ce, then 1 → exactly one clear pulse-level, held until ready=0, and no line command before ready returns to 1.
- Sample x=12'd1234, y=-567, z=89, temp=412, fast sim → line1 "X:+1234 Y:-0567 ", line2 "Z:+0089 T:+0412 ", line1 command issued before line2.
- Extremes x=-2048, y=2047, z=0, temp=-1 → "X:-2048 Y:+2047 ", "Z:+0000 T:-0001 ".
- No i_accel_valid after one refresh → after a further 3 refresh periods, zero additional line commands.
- Three valid pulses within one period (last x=7) → one line1/line2 pair showing "X:+0007"; a pulse during ST_CONV causes a second pair next period.
- Assert i_rst_n=0 while in ST_L1_REQ → command outputs drop asynchronously same cycle, lines return to spaces, boot clear reissued after release.
